// File: rtl/sram_like_arb_2to1.sv
// Two-master to one-slave SRAM-like bus arbiter with an in-order ID FIFO for response routing.
// Optional ARB_RR_EN: round-robin on conflict; otherwise fixed priority with m1 winning.
module sram_like_arb_2to1 #(
    parameter int unsigned OT_LOG2 = 2
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_req,
    input  logic                m0_wr,
    input  logic [1:0]          m0_size,
    input  logic [3:0]          m0_wstrb,
    input  logic [31:0]         m0_addr,
    input  logic [31:0]         m0_wdata,
    output logic                m0_addr_ok,
    output logic                m0_data_ok,
    output logic [31:0]         m0_rdata,

    input  logic                m1_req,
    input  logic                m1_wr,
    input  logic [1:0]          m1_size,
    input  logic [3:0]          m1_wstrb,
    input  logic [31:0]         m1_addr,
    input  logic [31:0]         m1_wdata,
    output logic                m1_addr_ok,
    output logic                m1_data_ok,
    output logic [31:0]         m1_rdata,

    output logic                s_req,
    output logic                s_wr,
    output logic [1:0]          s_size,
    output logic [3:0]          s_wstrb,
    output logic [31:0]         s_addr,
    output logic [31:0]         s_wdata,
    input  logic                s_addr_ok,
    input  logic                s_data_ok,
    input  logic [31:0]         s_rdata,

    output logic [OT_LOG2:0]    ot_cnt
);

    localparam int unsigned DEPTH = 2 ** OT_LOG2;
    localparam int unsigned CNT_W = OT_LOG2 + 1;

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             id_mem [DEPTH];
    logic             last_grant;

    logic grant;
    logic granted_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_id;

    // Conflict resolution; grant=1 selects m1.
    always_comb begin
        grant = 1'b0;
        if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b1;
`endif
        end else if (m1_req) begin
            grant = 1'b1;
        end
    end

`ifndef ARB_RR_EN
    // Tracked for observability only in the fixed-priority build.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Occupancy: the pointer MSB separates full from empty.
    assign ot_cnt = wr_ptr - rd_ptr;
    assign full   = (ot_cnt == CNT_W'(DEPTH));
    assign empty  = (wr_ptr == rd_ptr);

    assign granted_req = grant ? m1_req : m0_req;
    assign s_req       = resetn & granted_req & ~full;
    assign s_wr        = grant ? m1_wr    : m0_wr;
    assign s_size      = grant ? m1_size  : m0_size;
    assign s_wstrb     = grant ? m1_wstrb : m0_wstrb;
    assign s_addr      = grant ? m1_addr  : m0_addr;
    assign s_wdata     = grant ? m1_wdata : m0_wdata;

    assign push       = s_req & s_addr_ok;
    assign m0_addr_ok = push & ~grant;
    assign m1_addr_ok = push & grant;

    // A response with nothing outstanding is dropped.
    assign pop        = resetn & s_data_ok & ~empty;
    assign head_id    = id_mem[rd_ptr[OT_LOG2-1:0]];
    assign m0_data_ok = pop & ~head_id;
    assign m1_data_ok = pop & head_id;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + CNT_W'(1);
                last_grant <= grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // ID storage needs no reset; entries are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[OT_LOG2-1:0]] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arb_2to1.sv
// Directed, table-driven bench for sram_like_arb_2to1; each row is one clock cycle.
module tb_sram_like_arb_2to1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  ot_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_like_arb_2to1 #(.OT_LOG2(2)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .ot_cnt(ot_cnt)
    );

    typedef struct {
        logic        rst;
        logic        m0_req;
        logic        m1_req;
        logic [31:0] m0_addr;
        logic [31:0] m1_addr;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic [4:0]  exp_hs;     // {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}
        logic [31:0] exp_addr;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add(input logic rst, input logic r0, input logic r1,
                       input logic aok, input logic dok, input logic [31:0] rdata,
                       input logic [4:0] hs, input logic [31:0] eaddr, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.m0_req = r0; v.m1_req = r1;
        v.m0_addr = 32'h0000_0100; v.m1_addr = 32'h0000_0200;
        v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp_hs = hs; v.exp_addr = eaddr; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive one row at the falling edge, check just after, then let the rising edge commit it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        resetn = ~v.rst;
        m0_req = v.m0_req; m1_req = v.m1_req;
        m0_addr = v.m0_addr; m1_addr = v.m1_addr;
        s_addr_ok = v.aok; s_data_ok = v.dok; s_rdata = v.rdata;
        #1;
        check($sformatf("row%0d_handshake", idx),
              32'({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}), 32'(v.exp_hs));
        check($sformatf("row%0d_ot_cnt", idx), 32'(ot_cnt), 32'(v.exp_cnt));
        if (v.exp_hs[4]) check($sformatf("row%0d_s_addr", idx), s_addr, v.exp_addr);
        if (v.exp_hs[1]) check($sformatf("row%0d_m0_rdata", idx), m0_rdata, v.rdata);
        if (v.exp_hs[0]) check($sformatf("row%0d_m1_rdata", idx), m1_rdata, v.rdata);
    endtask

    localparam logic [4:0] HS_NONE = 5'b00000;
    localparam logic [4:0] HS_A0   = 5'b11000;
    localparam logic [4:0] HS_A1   = 5'b10100;
    localparam logic [4:0] HS_D0   = 5'b00010;
    localparam logic [4:0] HS_D1   = 5'b00001;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    initial begin
        logic [4:0] hs;
        int m, p;

        resetn = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b0; m0_size = 2'd2; m0_wstrb = 4'hF; m0_addr = A0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'd2; m1_wstrb = 4'hF; m1_addr = A1; m1_wdata = '0;
        s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = '0;

        // Reset state: outputs gated even with a pending request and response.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_s_req", 32'(s_req), 32'd0);
        check("reset_handshakes", 32'({m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}), 32'd0);
        check("reset_ot_cnt", 32'(ot_cnt), 32'd0);

        // Single read by m0, response next cycle.
        add(0, 1, 0, 1, 0, 32'h0,         HS_A0,   A0, 3'd0);
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, HS_D0,   A0, 3'd1);
        // Conflict after an m0 accept: m1 wins in both arbitration modes.
        add(0, 1, 1, 1, 0, 32'h0,         HS_A1,   A1, 3'd0);
        add(0, 1, 0, 1, 0, 32'h0,         HS_A0,   A0, 3'd1);
        add(0, 0, 0, 0, 1, 32'h0000_00A1, HS_D1,   A0, 3'd2);
        add(0, 0, 0, 0, 1, 32'h0000_00A0, HS_D0,   A0, 3'd1);
        add(0, 0, 0, 0, 0, 32'h0,         HS_NONE, A0, 3'd0);
        // Fill to four outstanding, then blocked, including the same-cycle pop.
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 32'h0, HS_A0, A0, 3'(i));
        add(0, 1, 0, 1, 0, 32'h0,         HS_NONE, A0, 3'd4);
        add(0, 1, 0, 1, 1, 32'h0000_0011, HS_D0,   A0, 3'd4);
        add(0, 1, 0, 1, 0, 32'h0,         HS_A0,   A0, 3'd3);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 32'h0000_0020 + 32'(i), HS_D0, A0, 3'(4 - i));
        // Response with nothing outstanding is dropped.
        add(0, 0, 0, 0, 1, 32'h0000_0BAD, HS_NONE, A0, 3'd0);
        add(0, 0, 0, 0, 0, 32'h0,         HS_NONE, A0, 3'd0);
        // Accept and respond every cycle with alternating masters; pointers wrap.
        add(0, 1, 0, 1, 0, 32'h0,         HS_A0,   A0, 3'd0);
        for (int k = 1; k <= 10; k++) begin
            m = k % 2;
            p = (k - 1) % 2;
            hs = (m == 1 ? HS_A1 : HS_A0) | (p == 1 ? HS_D1 : HS_D0);
            add(0, m == 0, m == 1, 1, 1, 32'h0000_4000 + 32'(k), hs, m == 1 ? A1 : A0, 3'd1);
        end
        add(0, 0, 0, 0, 1, 32'h0000_400B, HS_D0,   A0, 3'd1);
        add(0, 0, 0, 0, 0, 32'h0,         HS_NONE, A0, 3'd0);
        // Reset with three outstanding, then a stale response is dropped.
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, 32'h0, HS_A0, A0, 3'(i));
        add(1, 1, 0, 1, 1, 32'h0000_0077, HS_NONE, A0, 3'd3);
        add(0, 0, 0, 0, 0, 32'h0,         HS_NONE, A0, 3'd0);
        add(0, 0, 0, 0, 1, 32'h0000_0078, HS_NONE, A0, 3'd0);
        // First conflict after reset: round robin favours m0, fixed priority m1.
`ifdef ARB_RR_EN
        add(0, 1, 1, 1, 0, 32'h0,         HS_A0,   A0, 3'd0);
        add(0, 0, 0, 0, 1, 32'h0000_0055, HS_D0,   A0, 3'd1);
`else
        add(0, 1, 1, 1, 0, 32'h0,         HS_A1,   A1, 3'd0);
        add(0, 0, 0, 0, 1, 32'h0000_0055, HS_D1,   A0, 3'd1);
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // m1 write: all slave fields follow m1, ack routed back to m1.
        @(negedge clk);
        resetn = 1'b1; s_data_ok = 1'b0; s_addr_ok = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b1; m1_wr = 1'b1; m1_size = 2'd1; m1_wstrb = 4'b0011;
        m1_addr = 32'h0000_2002; m1_wdata = 32'h0000_1234;
        #1;
        check("wr_s_req", 32'(s_req), 32'd1);
        check("wr_m1_addr_ok", 32'(m1_addr_ok), 32'd1);
        check("wr_s_wr", 32'(s_wr), 32'd1);
        check("wr_s_size", 32'(s_size), 32'd1);
        check("wr_s_wstrb", 32'(s_wstrb), 32'b0011);
        check("wr_s_addr", s_addr, 32'h0000_2002);
        check("wr_s_wdata", s_wdata, 32'h0000_1234);
        @(negedge clk);
        m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = '0;
        #1;
        check("wr_ack_m1_data_ok", 32'(m1_data_ok), 32'd1);
        check("wr_ack_m0_data_ok", 32'(m0_data_ok), 32'd0);
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        check("wr_done_ot_cnt", 32'(ot_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
